fsqrt_sched: RTL and testbench

FSQRT_SCHED -- requirements
Module: fsqrt_sched

---
 rtl/fsqrt_sched.sv | 159 +++++++++++++++
 tb/tb_fsqrt_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_sched.sv
// Round-robin scheduler sharing one external combinational square-root unit among NREQ requesters.
// Optional macro FSQRT_SCHED_INV_EN turns negative non-zero operands into a quiet NaN with rsp_inv set.
module fsqrt_sched #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          sqrt_in,
  input  logic [31:0]          sqrt_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [2:0]           rsp_id,
  output logic                 rsp_inv
);

  localparam int PW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [PW-1:0]   ptr;
  logic [2:0]      tag;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic [CW-1:0]   count;

  logic [NREQ-1:0] grant_oh;
  logic [2:0]      grant_idx;
  logic [31:0]     grant_data;
  logic            grant_any;
  logic            can_issue;
  logic            handshake;
  logic            push;
  logic            pop;
  logic [31:0]     push_data;

  logic [31:0]     mem_data [DEPTH];
  logic [2:0]      mem_id   [DEPTH];

`ifdef FSQRT_SCHED_INV_EN
  logic            inv_q;
  logic            mem_inv  [DEPTH];
`endif

  // Search from the pointer to the top first, then wrap to the indices below it.
  always_comb begin
    grant_oh   = '0;
    grant_idx  = '0;
    grant_data = '0;
    grant_any  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[i] && (i >= int'(ptr))) begin
        grant_any   = 1'b1;
        grant_oh[i] = 1'b1;
        grant_idx   = 3'(i);
        grant_data  = req_data[32*i +: 32];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[i] && (i < int'(ptr))) begin
        grant_any   = 1'b1;
        grant_oh[i] = 1'b1;
        grant_idx   = 3'(i);
        grant_data  = req_data[32*i +: 32];
      end
    end
  end

  // Issue only when the FIFO can absorb the result, so a push can never overflow.
  assign can_issue = rst_n && (state == IDLE) && (count < CW'(DEPTH));
  assign req_ready = can_issue ? grant_oh : '0;
  assign handshake = can_issue && grant_any;
  assign push      = (state == BUSY) && (cnt == 4'd0);
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

`ifdef FSQRT_SCHED_INV_EN
  assign push_data = inv_q ? 32'h7FC0_0000 : sqrt_out;
  assign rsp_inv   = rsp_valid ? mem_inv[rd_idx] : 1'b0;
`else
  assign push_data = sqrt_out;
  assign rsp_inv   = 1'b0;
`endif

  assign rsp_data = rsp_valid ? mem_data[rd_idx] : '0;
  assign rsp_id   = rsp_valid ? mem_id[rd_idx]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      tag     <= '0;
      sqrt_in <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      count   <= '0;
`ifdef FSQRT_SCHED_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            sqrt_in <= grant_data;
            tag     <= grant_idx;
            ptr     <= PW'((int'(grant_idx) + 1) % NREQ);
            cnt     <= 4'(LAT - 1);
            state   <= BUSY;
`ifdef FSQRT_SCHED_INV_EN
            inv_q   <= grant_data[31] && (grant_data[30:0] != 31'd0);
`endif
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (pop) begin
        rd_idx <= rd_idx + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_idx] <= push_data;
      mem_id[wr_idx]   <= tag;
`ifdef FSQRT_SCHED_INV_EN
      mem_inv[wr_idx]  <= inv_q;
`endif
    end
  end

endmodule

// File: tb/tb_fsqrt_sched.sv
// Directed bench for fsqrt_sched (NREQ=4, LAT=2, DEPTH=2) with a lookup-table model of the sqrt unit.
module tb_fsqrt_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  sqrt_in;
  logic [31:0]  sqrt_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [2:0]   rsp_id;
  logic         rsp_inv;

  int total = 0;
  int bad   = 0;

  fsqrt_sched #(.NREQ(4), .LAT(2), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sqrt_in   (sqrt_in),
    .sqrt_out  (sqrt_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_inv   (rsp_inv)
  );

  always #5 clk = ~clk;

  // Stand-in for the external square-root unit: exact results for the operands used here.
  function automatic logic [31:0] sqrt_model(input logic [31:0] x);
    case (x)
      32'h4080_0000: sqrt_model = 32'h4000_0000;
      32'h4000_0000: sqrt_model = 32'h3FB5_04F3;
      32'h4110_0000: sqrt_model = 32'h4040_0000;
      32'h4180_0000: sqrt_model = 32'h4080_0000;
      32'h3F80_0000: sqrt_model = 32'h3F80_0000;
      32'h8000_0000: sqrt_model = 32'h8000_0000;
      default:       sqrt_model = x ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign sqrt_out = sqrt_model(sqrt_in);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic ready);
    req_valid = valid;
    rsp_ready = ready;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_data  = {32'h3F80_0000, 32'h4180_0000, 32'h4080_0000, 32'h4000_0000};
    settle();

    check_output("rst_req_ready", 32'(req_ready), 32'h0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("rst_rsp_data",  rsp_data,       32'h0);
    check_output("rst_rsp_id",    32'(rsp_id),    32'h0);
    check_output("rst_rsp_inv",   32'(rsp_inv),   32'h0);
    check_output("rst_sqrt_in",   sqrt_in,        32'h0);
    step();
    step();
    rst_n = 1'b1;
    apply_stimulus(4'h0, 1'b1);
    step();

    // Single request on requester 1: 4.0 -> 2.0
    apply_stimulus(4'b0010, 1'b1);
    check_output("single_grant", 32'(req_ready), 32'b0010);
    step();
    apply_stimulus(4'h0, 1'b1);
    check_output("single_busy_ready", 32'(req_ready), 32'h0);
    check_output("single_sqrt_in", sqrt_in, 32'h4080_0000);
    check_output("single_early_t1", 32'(rsp_valid), 32'h0);
    step();
    check_output("single_early_t2", 32'(rsp_valid), 32'h0);
    check_output("single_sqrt_hold", sqrt_in, 32'h4080_0000);
    step();
    check_output("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check_output("single_rsp_data", rsp_data, 32'h4000_0000);
    check_output("single_rsp_id", 32'(rsp_id), 32'h1);
    check_output("single_rsp_inv", 32'(rsp_inv), 32'h0);
    step();
    check_output("single_popped", 32'(rsp_valid), 32'h0);

    // Reset to bring the pointer back to 0, then round-robin across all four
    rst_n = 1'b0;
    settle();
    step();
    rst_n = 1'b1;
    req_data = {32'h3F80_0000, 32'h4180_0000, 32'h4110_0000, 32'h4000_0000};
    apply_stimulus(4'hF, 1'b1);
    check_output("rr_grant0", 32'(req_ready), 32'b0001);
    step();
    step();
    step();
    check_output("rr_id0", 32'(rsp_id), 32'd0);
    check_output("rr_data0", rsp_data, 32'h3FB5_04F3);
    check_output("rr_grant1", 32'(req_ready), 32'b0010);
    step();
    step();
    step();
    check_output("rr_id1", 32'(rsp_id), 32'd1);
    check_output("rr_data1", rsp_data, 32'h4040_0000);
    check_output("rr_grant2", 32'(req_ready), 32'b0100);
    step();
    step();
    step();
    check_output("rr_id2", 32'(rsp_id), 32'd2);
    check_output("rr_data2", rsp_data, 32'h4080_0000);
    check_output("rr_grant3", 32'(req_ready), 32'b1000);
    step();
    step();
    step();
    check_output("rr_id3", 32'(rsp_id), 32'd3);
    check_output("rr_data3", rsp_data, 32'h3F80_0000);
    check_output("rr_grant0_again", 32'(req_ready), 32'b0001);
    step();
    step();
    step();
    check_output("rr_id0_again", 32'(rsp_id), 32'd0);
    check_output("rr_data0_again", rsp_data, 32'h3FB5_04F3);
    apply_stimulus(4'h0, 1'b1);
    step();
    check_output("rr_drained", 32'(rsp_valid), 32'h0);

    // Back-pressure: exactly two grants fill the FIFO (pointer now at 1)
    apply_stimulus(4'hF, 1'b0);
    check_output("bp_grant1", 32'(req_ready), 32'b0010);
    step();
    step();
    step();
    check_output("bp_grant2", 32'(req_ready), 32'b0100);
    step();
    step();
    step();
    check_output("bp_full_ready", 32'(req_ready), 32'h0);
    check_output("bp_head_id", 32'(rsp_id), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check_output("bp_hold_ready", 32'(req_ready), 32'h0);
      check_output("bp_hold_id", 32'(rsp_id), 32'd1);
      check_output("bp_hold_data", rsp_data, 32'h4040_0000);
    end
    apply_stimulus(4'hF, 1'b1);
    step();
    rsp_ready = 1'b0;
    settle();
    check_output("bp_drain_id2", 32'(rsp_id), 32'd2);
    check_output("bp_drain_data2", rsp_data, 32'h4080_0000);
    check_output("bp_resume_grant", 32'(req_ready), 32'b1000);
    step();
    apply_stimulus(4'h0, 1'b0);
    step();
    rsp_ready = 1'b1;
    settle();
    step();
    check_output("pushpop_valid", 32'(rsp_valid), 32'h1);
    check_output("pushpop_id", 32'(rsp_id), 32'd3);
    check_output("pushpop_data", rsp_data, 32'h3F80_0000);
    step();
    check_output("pushpop_no_dup", 32'(rsp_valid), 32'h0);

    // Reset while BUSY discards the in-flight operation
    apply_stimulus(4'b1000, 1'b1);
    check_output("rb_grant3", 32'(req_ready), 32'b1000);
    step();
    apply_stimulus(4'h0, 1'b1);
    check_output("rb_busy_sqrt_in", sqrt_in, 32'h3F80_0000);
    rst_n = 1'b0;
    settle();
    check_output("rb_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("rb_sqrt_in", sqrt_in, 32'h0);
    check_output("rb_req_ready", 32'(req_ready), 32'h0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("rb_no_stale", 32'(rsp_valid), 32'h0);
    end
    apply_stimulus(4'b1010, 1'b1);
    check_output("rb_lowest_grant", 32'(req_ready), 32'b0010);
    step();
    apply_stimulus(4'h0, 1'b1);
    step();
    step();
    check_output("rb_rsp_id", 32'(rsp_id), 32'd1);
    check_output("rb_rsp_data", rsp_data, 32'h4040_0000);

    // Negative operand, then -0.0
    req_data = {32'h8000_0000, 32'hC080_0000, 32'h4110_0000, 32'h4000_0000};
    apply_stimulus(4'b0100, 1'b1);
    check_output("neg_grant", 32'(req_ready), 32'b0100);
    step();
    apply_stimulus(4'h0, 1'b1);
    step();
    step();
    check_output("neg_id", 32'(rsp_id), 32'd2);
`ifdef FSQRT_SCHED_INV_EN
    check_output("neg_data", rsp_data, 32'h7FC0_0000);
    check_output("neg_inv", 32'(rsp_inv), 32'h1);
`else
    check_output("neg_data", rsp_data, 32'h9ADA_0000);
    check_output("neg_inv", 32'(rsp_inv), 32'h0);
`endif
    apply_stimulus(4'b1000, 1'b1);
    check_output("nzero_grant", 32'(req_ready), 32'b1000);
    step();
    apply_stimulus(4'h0, 1'b1);
    step();
    step();
    check_output("nzero_id", 32'(rsp_id), 32'd3);
    check_output("nzero_data", rsp_data, 32'h8000_0000);
    check_output("nzero_inv", 32'(rsp_inv), 32'h0);
    step();
    check_output("final_empty", 32'(rsp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
